// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and holds the IF/ID register.
// Priority per edge: branch redirect > freeze > flush > normal fetch.
module fetch_stage #(
  parameter int unsigned         ADDR_W   = 32,
  parameter int unsigned         INSTR_W  = 32,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  input  logic               flush,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_valid,
  output logic [31:0]        fetch_count
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic               if_valid_q, if_valid_d;
  logic [31:0]        fetch_count_q, fetch_count_d;
  logic [ADDR_W-1:0]  pc_plus4;

  assign pc_plus4 = pc_q + ADDR_W'(4);

  always_comb begin
    pc_d          = pc_q;
    if_pc_d       = if_pc_q;
    if_instr_d    = if_instr_q;
    if_valid_d    = if_valid_q;
    fetch_count_d = fetch_count_q;

    if (branch_taken) begin
      // Low address bits are masked so the PC stays word aligned.
      pc_d       = branch_addr & ALIGN_MASK;
      if_pc_d    = '0;
      if_instr_d = '0;
      if_valid_d = 1'b0;
    end else if (freeze) begin
      pc_d = pc_q;
    end else if (flush) begin
      pc_d       = pc_plus4;
      if_pc_d    = '0;
      if_instr_d = '0;
      if_valid_d = 1'b0;
    end else begin
      pc_d          = pc_plus4;
      if_pc_d       = pc_plus4;
      if_instr_d    = imem_data;
      if_valid_d    = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC & ALIGN_MASK;
      if_pc_q       <= '0;
      if_instr_q    <= '0;
      if_valid_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      if_pc_q       <= if_pc_d;
      if_instr_q    <= if_instr_d;
      if_valid_q    <= if_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_pc       = if_pc_q;
  assign if_instr    = if_instr_q;
  assign if_valid    = if_valid_q;
  assign fetch_count = fetch_count_q;

endmodule
